mmc1_serial_mapper: RTL and testbench
=====================================

// Module: mmc1_serial_mapper
// PURPOSE
//  Next-generation MMC1 (SxROM) mapper: 5-bit serial-port register loader, consecutive-write filter,
//  PRG/CHR/PRG-RAM bank translation with selectable board variants (SNROM/SUROM/SOROM/SXROM).
//  Sits between the CPU/PPU bus decoders and the SDRAM address mux, like all cartridge mappers.
//  Widens PRG to 512 KB and PRG-RAM to 32 KB versus the base MMC1 block.
// PARAMETERS
//  PRG_OUTER_W   1   outer 256 KB PRG bits taken from CHR bank reg (0 = no outer banking)
//  RAM_BANK_W    2   PRG-RAM 8 KB bank select bits (0..2)
//  CHR_BANK_W    5   CHR 4 KB bank register width
// PORTS
//  clk         in   1   system clock
//  reset       in   1   synchronous, active-high reset
//  ce          in   1   CPU-cycle enable; all state updates qualified by ce
//  board_mode  in   2   0 SNROM, 1 SUROM, 2 SOROM, 3 SXROM (static after reset)
//  prg_ain     in   16  CPU address
//  prg_read    in   1   CPU read strobe
//  prg_write   in   1   CPU write strobe
//  prg_din     in   8   CPU write data
//  prg_aout    out  22  linear PRG ROM/RAM address
//  prg_allow   out  1   access permitted
//  chr_ain     in   14  PPU address
//  chr_aout    out  22  linear CHR address
//  chr_allow   out  1   CHR write permitted (CHR-RAM carts)
//  chr_ram     in   1   cart uses CHR-RAM
//  vram_a10    out  1   CIRAM A10 (mirroring)
//  vram_ce     out  1   route PPU access to CIRAM
// BEHAVIOUR
//  Reset: shift=5'b10000, control=5'b01100, chr0=chr1=prg=0, filt=0. Hence at reset exit:
//   vram_a10=0, PRG mode 3 ($C000 fixed to last bank), prg_aout from prg bank 0 at $8000.
//  Write accept: (ce & prg_write & prg_ain[15] & !filt). filt<=1 on any ce with prg_write, 0 on ce
//   without; back-to-back write cycles (RMW dummy+real) accept only the first.
//  Accepted write, din[7]=1: shift<=10000, control<=control|01100; other regs unchanged.
//  Accepted write, din[7]=0: if shift[0]=0 shift<={din[0],shift[4:1]}; else commit
//   {din[0],shift[4:1]} to reg chosen by prg_ain[14:13] (0 ctrl,1 chr0,2 chr1,3 prg), shift<=10000.
//   Exactly 5 accepted writes commit; new mapping visible on the clk after the committing ce.
//  Writes with prg_ain[15]=0 never touch shift/filter-independent regs (filter still tracks).
//  PRG mode ctrl[3:2]: 0/1 32 KB {prg[3:1],A14}; 2 $8000=bank0,$C000=prg[3:0]; 3 $8000=prg[3:0],$C000=4'hF.
//  CHR: ctrl[4]=0 {chr0[4:1],A12}; 1 A12?chr1:chr0. chr_aout={5'b10000,chrsel,chr_ain[11:0]}.
//  Outer/RAM bits from active chrsel (tracks PPU A12 live): SUROM/SXROM chrsel[4]->PRG A18;
//   SXROM chrsel[3:2]->RAM bank; SOROM chrsel[3]->RAM bank[1] (bank[0]=0); SNROM RAM bank 0.
//  prg_aout: ROM={3'b000,outer,prgsel,A[13:0]}; RAM ($6000-7FFF)={9'b111100000 w/ ram bank in [14:13],A[12:0]}.
//  Mirroring ctrl[1:0]: 0 A10=0, 1 A10=1, 2 chr_ain[10], 3 chr_ain[11]. vram_ce=chr_ain[13].
//  prg_allow=(A15 & !prg_write)|ram_window(&enable). chr_allow=chr_ram.
//  Simultaneous reset+write: reset wins. ce=0: no state change, outputs remain combinational.
// CONFIGURATION
//  MMC1_WRAM_PROTECT_EN defined: prg[4]=1 disables PRG-RAM (prg_allow=0 in $6000-7FFF, reads
//   open bus); SNROM additionally disables RAM when chrsel[4]=1.
//  Undefined: PRG-RAM always enabled (MMC1A behaviour); prg[4] stored but ignored.
// STRUCTURE
//  Package mmc1_pkg: board_mode enum, PRG mode enum, mirroring enum, SHIFT_RESET=5'b10000,
//   CTRL_RESET=5'b01100, RAM_BASE=9'b111100000, CHR_BASE=5'b10000.
//  Sub-module mmc1_serial_port: filter + shift + 4-register file; top does address translation.
// TESTING
//  Reset, read $C000 -> prg_aout=22'h03C000; read $8000 -> 22'h000000.
//  Write ctrl=5'b10010 via 5 writes to $8000 -> vram_a10 follows chr_ain[10]; 4 writes only -> no change.
//  Two writes on consecutive ce cycles (RMW) -> shift advances once; gap of one ce -> advances twice.
//  Write $80 mid-sequence after 3 bits -> shift=10000, control[3:2]=11, then 5 fresh writes commit.
//  SXROM, chr0=5'b11100, ctrl[4]=0: read $8000 -> prg_aout[18]=1; $6000 -> RAM bank 3 (22'h3C6000).
//  With MMC1_WRAM_PROTECT_EN, prg=5'b10000: $6000 write -> prg_allow=0; without macro -> 1.

Source files
------------

// File: rtl/mmc1_pkg.sv
// Shared types and constants for the MMC1 serial mapper.
package mmc1_pkg;

  typedef enum logic [1:0] {
    BoardSnrom = 2'd0,
    BoardSurom = 2'd1,
    BoardSorom = 2'd2,
    BoardSxrom = 2'd3
  } board_e;

  typedef enum logic [1:0] {
    Prg32KLo    = 2'd0,
    Prg32KHi    = 2'd1,
    PrgFixFirst = 2'd2,
    PrgFixLast  = 2'd3
  } prg_mode_e;

  typedef enum logic [1:0] {
    MirOne0 = 2'd0,
    MirOne1 = 2'd1,
    MirVert = 2'd2,
    MirHorz = 2'd3
  } mirror_e;

  localparam logic [4:0] SHIFT_RESET = 5'b10000;
  localparam logic [4:0] CTRL_RESET  = 5'b01100;
  localparam logic [8:0] RAM_BASE    = 9'b111100000;
  localparam logic [4:0] CHR_BASE    = 5'b10000;

endpackage

// File: rtl/mmc1_serial_port.sv
// MMC1 serial loader: consecutive-write filter, 5-bit shift register and the
// four internal registers (control, chr0, chr1, prg).
module mmc1_serial_port
  import mmc1_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ce,
  input  logic       i_write,
  input  logic [2:0] i_addr_hi,  // CPU A15..A13
  input  logic       i_din7,
  input  logic       i_din0,
  output logic [4:0] o_ctrl,
  output logic [4:0] o_chr0,
  output logic [4:0] o_chr1,
  output logic [4:0] o_prg
);

  logic [4:0] r_shift;
  logic [4:0] r_ctrl;
  logic [4:0] r_chr0;
  logic [4:0] r_chr1;
  logic [4:0] r_prg;
  logic       r_filt;

  logic       w_accept;
  logic [4:0] w_value;

  // The filter drops the second of two back-to-back write cycles (RMW dummy+real).
  assign w_accept = i_ce & i_write & i_addr_hi[2] & ~r_filt;
  assign w_value  = {i_din0, r_shift[4:1]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift <= SHIFT_RESET;
      r_ctrl  <= CTRL_RESET;
      r_chr0  <= 5'd0;
      r_chr1  <= 5'd0;
      r_prg   <= 5'd0;
      r_filt  <= 1'b0;
    end else if (i_ce) begin
      r_filt <= i_write;
      if (w_accept) begin
        if (i_din7) begin
          r_shift <= SHIFT_RESET;
          r_ctrl  <= r_ctrl | CTRL_RESET;
        end else if (!r_shift[0]) begin
          r_shift <= w_value;
        end else begin
          // Marker bit reached bit 0: this is the fifth write, commit.
          r_shift <= SHIFT_RESET;
          unique case (i_addr_hi[1:0])
            2'd0: r_ctrl <= w_value;
            2'd1: r_chr0 <= w_value;
            2'd2: r_chr1 <= w_value;
            2'd3: r_prg  <= w_value;
          endcase
        end
      end
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_chr0 = r_chr0;
  assign o_chr1 = r_chr1;
  assign o_prg  = r_prg;

endmodule

// File: rtl/mmc1_serial_mapper.sv
// MMC1 (SxROM) mapper: serial register port plus PRG/CHR/PRG-RAM address translation.
// Optional MMC1_WRAM_PROTECT_EN enables PRG-RAM disable via prg[4] (and chrsel[4] on SNROM).
module mmc1_serial_mapper
  import mmc1_pkg::*;
#(
  parameter int unsigned PRG_OUTER_W = 1,
  parameter int unsigned RAM_BANK_W  = 2,
  parameter int unsigned CHR_BANK_W  = 5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce,
  input  logic [1:0]  i_board_mode,
  input  logic [15:0] i_prg_ain,
  input  logic        i_prg_read,
  input  logic        i_prg_write,
  input  logic [7:0]  i_prg_din,
  output logic [21:0] o_prg_aout,
  output logic        o_prg_allow,
  input  logic [13:0] i_chr_ain,
  output logic [21:0] o_chr_aout,
  output logic        o_chr_allow,
  input  logic        i_chr_ram,
  output logic        o_vram_a10,
  output logic        o_vram_ce
);

  localparam logic [4:0] CHR_MASK = 5'((1 << CHR_BANK_W) - 1);
  localparam logic [1:0] RAM_MASK = 2'((1 << RAM_BANK_W) - 1);

  logic [4:0] w_ctrl;
  logic [4:0] w_chr0_raw;
  logic [4:0] w_chr1_raw;
  logic [4:0] w_prg;
  logic [4:0] w_chr0;
  logic [4:0] w_chr1;
  logic [4:0] w_chrsel;
  logic [3:0] w_prgsel;
  logic [1:0] w_ram_bank;
  logic       w_outer;
  logic       w_ram_win;
  logic       w_ram_en;
  logic       w_unused;
  board_e     w_board;

  mmc1_serial_port u_port (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_ce      (i_ce),
    .i_write   (i_prg_write),
    .i_addr_hi (i_prg_ain[15:13]),
    .i_din7    (i_prg_din[7]),
    .i_din0    (i_prg_din[0]),
    .o_ctrl    (w_ctrl),
    .o_chr0    (w_chr0_raw),
    .o_chr1    (w_chr1_raw),
    .o_prg     (w_prg)
  );

  assign w_board = board_e'(i_board_mode);
  assign w_chr0  = w_chr0_raw & CHR_MASK;
  assign w_chr1  = w_chr1_raw & CHR_MASK;

  // Active CHR bank follows PPU A12 live; the board bits below derive from it too.
  assign w_chrsel = w_ctrl[4] ? (i_chr_ain[12] ? w_chr1 : w_chr0)
                              : {w_chr0[4:1], i_chr_ain[12]};

  always_comb begin
    w_outer    = 1'b0;
    w_ram_bank = 2'b00;
    unique case (w_board)
      BoardSnrom: ;
      BoardSurom: w_outer = w_chrsel[4];
      BoardSorom: w_ram_bank = {w_chrsel[3], 1'b0};
      BoardSxrom: begin
        w_outer    = w_chrsel[4];
        w_ram_bank = w_chrsel[3:2];
      end
    endcase
    if (PRG_OUTER_W == 0) w_outer = 1'b0;
    w_ram_bank = w_ram_bank & RAM_MASK;
  end

  always_comb begin
    w_prgsel = 4'h0;
    unique case (prg_mode_e'(w_ctrl[3:2]))
      Prg32KLo, Prg32KHi: w_prgsel = {w_prg[3:1], i_prg_ain[14]};
      PrgFixFirst:        w_prgsel = i_prg_ain[14] ? w_prg[3:0] : 4'h0;
      PrgFixLast:         w_prgsel = i_prg_ain[14] ? 4'hF : w_prg[3:0];
    endcase
  end

  assign w_ram_win = (i_prg_ain[15:13] == 3'b011);

`ifdef MMC1_WRAM_PROTECT_EN
  assign w_ram_en = ~w_prg[4] & ~((w_board == BoardSnrom) & w_chrsel[4]);
  assign w_unused = ^{i_prg_read, i_prg_din[6:1]};
`else
  assign w_ram_en = 1'b1;
  assign w_unused = ^{i_prg_read, i_prg_din[6:1], w_prg[4]};
`endif

  assign o_prg_aout  = w_ram_win ? {RAM_BASE | {7'd0, w_ram_bank}, i_prg_ain[12:0]}
                                 : {3'b000, w_outer, w_prgsel, i_prg_ain[13:0]};
  assign o_prg_allow = (i_prg_ain[15] & ~i_prg_write) | (w_ram_win & w_ram_en);

  assign o_chr_aout  = {CHR_BASE, w_chrsel, i_chr_ain[11:0]};
  assign o_chr_allow = i_chr_ram;
  assign o_vram_ce   = i_chr_ain[13];

  always_comb begin
    o_vram_a10 = 1'b0;
    unique case (mirror_e'(w_ctrl[1:0]))
      MirOne0: o_vram_a10 = 1'b0;
      MirOne1: o_vram_a10 = 1'b1;
      MirVert: o_vram_a10 = i_chr_ain[10];
      MirHorz: o_vram_a10 = i_chr_ain[11];
    endcase
  end

endmodule

// File: tb/tb_mmc1_serial_mapper.sv
// Self-checking bench for mmc1_serial_mapper: directed scenarios then random traffic
// against a behavioural model of the mapper registers.
module tb_mmc1_serial_mapper;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [1:0]  board_mode;
  logic [15:0] prg_ain;
  logic        prg_read;
  logic        prg_write;
  logic [7:0]  prg_din;
  logic [21:0] prg_aout;
  logic        prg_allow;
  logic [13:0] chr_ain;
  logic [21:0] chr_aout;
  logic        chr_allow;
  logic        chr_ram;
  logic        vram_a10;
  logic        vram_ce;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: registers plus a count of bits gathered so far.
  bit [4:0] m_ctrl, m_chr0, m_chr1, m_prg, m_acc;
  int       m_nbits;
  bit       m_last_wr;
  int       m_board;

  mmc1_serial_mapper dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_ce         (ce),
    .i_board_mode (board_mode),
    .i_prg_ain    (prg_ain),
    .i_prg_read   (prg_read),
    .i_prg_write  (prg_write),
    .i_prg_din    (prg_din),
    .o_prg_aout   (prg_aout),
    .o_prg_allow  (prg_allow),
    .i_chr_ain    (chr_ain),
    .o_chr_aout   (chr_aout),
    .o_chr_allow  (chr_allow),
    .i_chr_ram    (chr_ram),
    .o_vram_a10   (vram_a10),
    .o_vram_ce    (vram_ce)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset(input int b);
    m_ctrl = 5'd12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
    m_acc = 0; m_nbits = 0; m_last_wr = 0; m_board = b;
  endfunction

  function automatic void model_step(input logic w, input logic [15:0] a, input logic [7:0] d);
    bit acc;
    acc = w && a[15] && !m_last_wr;
    m_last_wr = w;
    if (!acc) return;
    if (d[7]) begin
      m_nbits = 0; m_acc = 0; m_ctrl = m_ctrl | 5'd12;
    end else begin
      m_acc = m_acc | (5'(d[0]) << m_nbits);
      m_nbits++;
      if (m_nbits == 5) begin
        case ((int'(a) / 32'h2000) % 4)
          0: m_ctrl = m_acc;
          1: m_chr0 = m_acc;
          2: m_chr1 = m_acc;
          default: m_prg = m_acc;
        endcase
        m_nbits = 0; m_acc = 0;
      end
    end
  endfunction

  function automatic int exp_sel(input int a12);
    if (m_ctrl[4]) return a12 != 0 ? int'(m_chr1) : int'(m_chr0);
    return (int'(m_chr0) / 2) * 2 + a12;
  endfunction

  function automatic void exp_prg(input logic [15:0] a, input logic wr, input logic [13:0] ca,
                                  output logic [21:0] aout, output logic allow);
    int sel, outer, bank, a14, b16, mode, ai;
    bit en;
    ai = int'(a);
    sel = exp_sel(int'(ca[12]));
    outer = (m_board == 1 || m_board == 3) ? sel / 16 : 0;
    case (m_board)
      3: bank = (sel / 4) % 4;
      2: bank = ((sel / 8) % 2) * 2;
      default: bank = 0;
    endcase
    en = 1'b1;
`ifdef MMC1_WRAM_PROTECT_EN
    if (m_prg >= 16 || (m_board == 0 && sel >= 16)) en = 1'b0;
`endif
    if (ai >= 32'h6000 && ai < 32'h8000) begin
      aout  = 22'(32'h3C0000 + bank * 32'h2000 + ai % 32'h2000);
      allow = en;
    end else begin
      a14  = (ai / 32'h4000) % 2;
      mode = (int'(m_ctrl) / 4) % 4;
      case (mode)
        0, 1: b16 = (int'(m_prg) % 16 / 2) * 2 + a14;
        2: b16 = a14 != 0 ? int'(m_prg) % 16 : 0;
        default: b16 = a14 != 0 ? 15 : int'(m_prg) % 16;
      endcase
      aout  = 22'(outer * 32'h40000 + b16 * 32'h4000 + ai % 32'h4000);
      allow = (ai >= 32'h8000) && !wr;
    end
  endfunction

  task automatic cyc(input logic c, input logic w, input logic [15:0] a, input logic [7:0] d);
    ce = c; prg_write = w; prg_read = !w; prg_ain = a; prg_din = d;
    @(posedge clk);
    if (c) model_step(w, a, d);
    #1;
  endtask

  task automatic do_reset(input int b);
    board_mode = 2'(b);
    reset = 1'b1; ce = 1'($urandom_range(0, 1));
    prg_write = 1'b1; prg_read = 1'b0; prg_ain = 16'h8000; prg_din = 8'h01;
    @(posedge clk);
    model_reset(b);
    #1;
    reset = 1'b0; prg_write = 1'b0;
  endtask

  task automatic serial_write(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b1, a, {7'd0, v[i]});
      cyc(1'b1, 1'b0, a, 8'h00);
    end
  endtask

  task automatic probe(input logic [15:0] a, input logic wr, input logic [13:0] ca);
    logic [21:0] ea;
    logic        el;
    logic        ev;
    @(negedge clk);
    ce = 1'b0; prg_ain = a; prg_write = wr; prg_read = !wr; chr_ain = ca;
    chr_ram = 1'($urandom_range(0, 1));
    #1;
    exp_prg(a, wr, ca, ea, el);
    case (int'(m_ctrl) % 4)
      0: ev = 1'b0;
      1: ev = 1'b1;
      2: ev = ca[10];
      default: ev = ca[11];
    endcase
    check("prg_aout", 32'(prg_aout), 32'(ea));
    check("prg_allow", 32'(prg_allow), 32'(el));
    check("chr_aout", 32'(chr_aout),
          32'(32'h200000 + exp_sel(int'(ca[12])) * 32'h1000 + int'(ca) % 32'h1000));
    check("vram_a10", 32'(vram_a10), 32'(ev));
    check("vram_ce", 32'(vram_ce), 32'(ca[13]));
    check("chr_allow", 32'(chr_allow), 32'(chr_ram));
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rd;
    int          n;
    reset = 1'b1; ce = 1'b0; board_mode = 2'd0; prg_ain = 16'h0; prg_read = 1'b0;
    prg_write = 1'b0; prg_din = 8'h0; chr_ain = 14'h0; chr_ram = 1'b0;

    // Reset state
    do_reset(0);
    probe(16'hC000, 1'b0, 14'h0400);
    check("reset_c000", 32'(prg_aout), 32'h03C000);
    check("reset_a10", 32'(vram_a10), 32'h0);
    probe(16'h8000, 1'b0, 14'h0000);
    check("reset_8000", 32'(prg_aout), 32'h000000);

    // Control write: four bits are not enough, the fifth commits
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 16'h8000, {7'd0, 1'(5'b10010 >> i)});
      cyc(1'b1, 1'b0, 16'h8000, 8'h00);
    end
    probe(16'h8000, 1'b0, 14'h0400);
    check("ctrl_4bits_a10", 32'(vram_a10), 32'h0);
    cyc(1'b1, 1'b1, 16'h8000, 8'h01);
    cyc(1'b1, 1'b0, 16'h8000, 8'h00);
    probe(16'h8000, 1'b0, 14'h0400);
    check("ctrl_5bits_a10_hi", 32'(vram_a10), 32'h1);
    probe(16'h8000, 1'b0, 14'h0000);
    check("ctrl_5bits_a10_lo", 32'(vram_a10), 32'h0);

    // RMW pair advances once; writes one idle cycle apart advance twice
    do_reset(0);
    cyc(1'b1, 1'b1, 16'hE000, 8'h01);
    cyc(1'b1, 1'b1, 16'hE000, 8'h00);
    cyc(1'b1, 1'b0, 16'hE000, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 16'hE000, 8'h00);
      cyc(1'b1, 1'b0, 16'hE000, 8'h00);
    end
    probe(16'h8000, 1'b0, 14'h0000);
    check("rmw_filter", 32'(prg_aout), 32'h004000);
    serial_write(16'hE000, 5'b00011);
    probe(16'h8000, 1'b0, 14'h0000);
    check("gap_two_writes", 32'(prg_aout), 32'h00C000);

    // $80 mid-sequence resets the shifter and forces PRG mode 3
    do_reset(0);
    serial_write(16'h8000, 5'b01000);
    probe(16'hC000, 1'b0, 14'h0000);
    check("mode2_c000", 32'(prg_aout), 32'h000000);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 16'hE000, 8'h01);
      cyc(1'b1, 1'b0, 16'hE000, 8'h00);
    end
    cyc(1'b1, 1'b1, 16'hE000, 8'h80);
    cyc(1'b1, 1'b0, 16'hE000, 8'h00);
    probe(16'hC000, 1'b0, 14'h0000);
    check("reset_write_mode3", 32'(prg_aout), 32'h03C000);
    serial_write(16'hE000, 5'b00101);
    probe(16'h8000, 1'b0, 14'h0000);
    check("fresh_commit", 32'(prg_aout), 32'h014000);

    // SXROM outer bank and RAM bank from chr0
    do_reset(3);
    serial_write(16'hA000, 5'b11100);
    probe(16'h8000, 1'b0, 14'h0000);
    check("sxrom_outer", 32'(prg_aout), 32'h040000);
    probe(16'h6000, 1'b0, 14'h0000);
    check("sxrom_ram", 32'(prg_aout), 32'h3C6000);

    // PRG-RAM protect bit
    serial_write(16'hE000, 5'b10000);
    probe(16'h6000, 1'b1, 14'h0000);
`ifdef MMC1_WRAM_PROTECT_EN
    check("wram_protect", 32'(prg_allow), 32'h0);
`else
    check("wram_protect", 32'(prg_allow), 32'h1);
`endif

    // Random traffic against the model
    do_reset(int'($urandom_range(0, 3)));
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(0, 39) == 0) do_reset(int'($urandom_range(0, 3)));
      n = int'($urandom_range(1, 8));
      for (int k = 0; k < n; k++) begin
        ra = 16'($urandom);
        if ($urandom_range(0, 4) != 0) ra[15] = 1'b1;
        rd = 8'($urandom);
        if ($urandom_range(0, 9) != 0) rd[7] = 1'b0;
        cyc(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 2) != 0), ra, rd);
      end
      probe(16'(32'h6000 + $urandom_range(0, 32'h9FFF)), 1'($urandom_range(0, 1)),
            14'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
